// File: rtl/pattern_stream_pkg.sv
// Shared constants and width helpers for the pattern stream controller and its matcher.
package pattern_stream_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Power-up configuration reproduces the legacy fixed "101" detector.
    localparam int   DEF_PATTERN = 5;
    localparam int   DEF_LEN     = 3;
    localparam logic DEF_OVERLAP = 1'b1;

    function automatic int len_width(input int pat_max);
        return $clog2(pat_max + 1);
    endfunction

    function automatic int bitcnt_width(input int data_w);
        return (data_w > 1) ? $clog2(data_w) : 1;
    endfunction

endpackage

// File: rtl/pattern_stream_ctrl_matcher.sv
// Programmable Mealy pattern matcher: keeps a bit history and flags a match in the
// same cycle the final pattern bit is presented.
module pattern_matcher
    import pattern_stream_pkg::*;
#(
    parameter int PAT_MAX = 8,
    parameter int LEN_W   = len_width(PAT_MAX)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               bit_valid,
    input  logic               bit_in,
    input  logic [PAT_MAX-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    input  logic               clear,
    output logic               match
);

    logic [PAT_MAX-1:0] hist;
    logic [PAT_MAX-1:0] window;
    logic [PAT_MAX-1:0] mask;
    logic [LEN_W-1:0]   seen;
    logic               enough;

    // Newest bit sits at window[0] and lines up with pattern[0].
    assign window = {hist[PAT_MAX-2:0], bit_in};

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_MAX; i++) begin
            mask[i] = (i < int'(len));
        end
    end

    assign enough = (len != '0) && (seen >= len - LEN_W'(1));
    assign match  = bit_valid && enough && (((window ^ pattern) & mask) == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= '0;
            seen <= '0;
        end else if (clear) begin
            hist <= '0;
            seen <= '0;
        end else if (bit_valid) begin
            if (match && !overlap) begin
                hist <= '0;
                seen <= '0;
            end else begin
                hist <= window;
                if (seen != LEN_W'(PAT_MAX)) begin
                    seen <= seen + LEN_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pattern_stream_ctrl.sv
// Byte-to-bit serialiser feeding a programmable pattern matcher, with config
// registers and a saturating match counter.
module pattern_stream_ctrl
    import pattern_stream_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PAT_MAX = 8,
    parameter int CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cfg_we,
    input  logic [PAT_MAX-1:0]          cfg_pattern,
    input  logic [len_width(PAT_MAX)-1:0] cfg_len,
    input  logic                        cfg_overlap,
    output logic                        cfg_err,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_W-1:0]           s_data,
    output logic                        busy,
    output logic                        ser_bit,
    output logic                        out,
    input  logic                        cnt_clr,
    output logic [CNT_W-1:0]            match_cnt
);

    localparam int LEN_W = len_width(PAT_MAX);
    localparam int BC_W  = bitcnt_width(DATA_W);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);

    logic [0:0]         state;
    logic [DATA_W-1:0]  shreg;
    logic [BC_W-1:0]    bitcnt;
    logic [PAT_MAX-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic               cfg_take;
    logic               match;

    // Handshake: a word transfers on any rising edge where s_valid && s_ready;
    // s_ready is high in IDLE and on the last bit cycle of the word being shifted,
    // and s_data must stay stable while s_valid is high and s_ready is low.
    assign busy     = (state == ST_SHIFT);
    assign s_ready  = (state == ST_IDLE) || (bitcnt == '0);
    assign ser_bit  = busy && shreg[DATA_W-1];
    assign cfg_take = cfg_we && !busy;
    assign out      = match;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            shreg  <= '0;
            bitcnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s_valid) begin
                        shreg  <= s_data;
                        bitcnt <= BC_LAST;
                        state  <= ST_SHIFT;
                    end
                end
                default: begin
                    if (bitcnt == '0) begin
                        // Reload on the last bit so consecutive words leave no gap.
                        if (s_valid) begin
                            shreg  <= s_data;
                            bitcnt <= BC_LAST;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        shreg  <= {shreg[DATA_W-2:0], 1'b0};
                        bitcnt <= bitcnt - BC_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_q <= PAT_MAX'(DEF_PATTERN);
            len_q     <= LEN_W'(DEF_LEN);
            overlap_q <= DEF_OVERLAP;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= cfg_we && busy;
            if (cfg_take) begin
                pattern_q <= cfg_pattern;
                len_q     <= (cfg_len > LEN_W'(PAT_MAX)) ? LEN_W'(PAT_MAX) : cfg_len;
                overlap_q <= cfg_overlap;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_cnt <= '0;
        end else if (cnt_clr) begin
            match_cnt <= match ? CNT_W'(1) : '0;
        end else if (match && !(&match_cnt)) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end

    pattern_matcher #(
        .PAT_MAX (PAT_MAX),
        .LEN_W   (LEN_W)
    ) u_matcher (
        .clk       (clk),
        .reset     (reset),
        .bit_valid (busy),
        .bit_in    (ser_bit),
        .pattern   (pattern_q),
        .len       (len_q),
        .overlap   (overlap_q),
        .clear     (cfg_take),
        .match     (match)
    );

endmodule

// File: tb/tb_pattern_stream_ctrl.sv
// Bench for pattern_stream_ctrl: a queue-based reference model checked every cycle,
// a table of single-word cases, and hand sequences for multi-cycle corners.
module tb_pattern_stream_ctrl;

    logic        clk;
    logic        reset;
    logic        cfg_we;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic        cfg_overlap;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        cnt_clr;
    logic        cfg_err, s_ready, busy, ser_bit, out;
    logic [15:0] match_cnt;
    logic        cfg_err2, s_ready2, busy2, ser_bit2, out2;
    logic [1:0]  match_cnt2;

    int n_vec;
    int n_err;

    pattern_stream_ctrl #(.DATA_W(8), .PAT_MAX(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .busy(busy),
        .ser_bit(ser_bit), .out(out), .cnt_clr(cnt_clr), .match_cnt(match_cnt)
    );

    pattern_stream_ctrl #(.DATA_W(8), .PAT_MAX(8), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err2),
        .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data), .busy(busy2),
        .ser_bit(ser_bit2), .out(out2), .cnt_clr(cnt_clr), .match_cnt(match_cnt2)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic exp_bits[$];   // bits still to be presented, front = current bit
    logic hist_q[$];     // bits presented since the last history clear
    logic [7:0] m_pat;
    int   m_len;
    logic m_ovl;
    int   m_cnt16;
    int   m_cnt2;
    logic m_cfg_err;

    logic obs_out, obs_ready, obs_busy, obs_err;
    int   obs_cnt, obs_cnt2;

    task automatic model_reset();
        exp_bits.delete();
        hist_q.delete();
        m_pat     = 8'h05;
        m_len     = 3;
        m_ovl     = 1'b1;
        m_cnt16   = 0;
        m_cnt2    = 0;
        m_cfg_err = 1'b0;
    endtask

    // The newest bit must equal pattern[0], the one before it pattern[1], and so on.
    function automatic logic model_match(input logic b);
        if (exp_bits.size() == 0 || m_len == 0) return 1'b0;
        if (hist_q.size() < m_len - 1) return 1'b0;
        for (int d = 0; d < m_len; d++) begin
            logic v;
            v = (d == 0) ? b : hist_q[hist_q.size() - d];
            if (v != m_pat[d]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // One clock cycle: inputs already driven; check outputs mid-cycle, then advance the model.
    task automatic tick();
        logic e_busy, e_ready, e_ser, e_out;
        #2;
        e_busy  = (exp_bits.size() > 0);
        e_ready = (exp_bits.size() <= 1);
        e_ser   = e_busy ? exp_bits[0] : 1'b0;
        e_out   = model_match(e_ser);
        chk("s_ready",    32'(s_ready),    32'(e_ready));
        chk("busy",       32'(busy),       32'(e_busy));
        chk("ser_bit",    32'(ser_bit),    32'(e_ser));
        chk("out",        32'(out),        32'(e_out));
        chk("cfg_err",    32'(cfg_err),    32'(m_cfg_err));
        chk("match_cnt",  32'(match_cnt),  32'(m_cnt16));
        chk("match_cnt2", 32'(match_cnt2), 32'(m_cnt2));
        obs_out   = out;
        obs_ready = s_ready;
        obs_busy  = busy;
        obs_err   = cfg_err;
        obs_cnt   = int'(match_cnt);
        obs_cnt2  = int'(match_cnt2);
        @(posedge clk);
        if (cfg_we && !e_busy) begin
            m_pat = cfg_pattern;
            m_len = (cfg_len > 8) ? 8 : int'(cfg_len);
            m_ovl = cfg_overlap;
            hist_q.delete();
        end else if (e_busy) begin
            if (e_out && !m_ovl) hist_q.delete();
            else begin
                hist_q.push_back(e_ser);
                if (hist_q.size() > 8) void'(hist_q.pop_front());
            end
        end
        m_cfg_err = cfg_we && e_busy;
        if (cnt_clr) begin
            m_cnt16 = e_out ? 1 : 0;
            m_cnt2  = e_out ? 1 : 0;
        end else if (e_out) begin
            m_cnt16 = (m_cnt16 == 65535) ? 65535 : m_cnt16 + 1;
            m_cnt2  = (m_cnt2 == 3) ? 3 : m_cnt2 + 1;
        end
        if (e_busy) void'(exp_bits.pop_front());
        if (s_valid && e_ready) begin
            for (int i = 7; i >= 0; i--) exp_bits.push_back(s_data[i]);
        end
        #1;
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        cfg_we  = 1'b0;
        cnt_clr = 1'b0;
        reset   = 1'b1;
        #1;
        chk("rst_out",     32'(out),        32'd0);
        chk("rst_busy",    32'(busy),       32'd0);
        chk("rst_s_ready", 32'(s_ready),    32'd1);
        chk("rst_ser_bit", 32'(ser_bit),    32'd0);
        chk("rst_cfg_err", 32'(cfg_err),    32'd0);
        chk("rst_cnt",     32'(match_cnt),  32'd0);
        chk("rst_cnt2",    32'(match_cnt2), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Sends one word (already accepted on the first tick) and records 8 presentation cycles.
    task automatic send_word(input logic [7:0] w, output logic [7:0] pulses);
        s_valid = 1'b1;
        s_data  = w;
        tick();
        s_valid = 1'b0;
        cfg_we  = 1'b0;
        pulses  = '0;
        for (int k = 0; k < 8; k++) begin
            tick();
            pulses[k] = obs_out;
        end
    endtask

    typedef struct {
        logic [7:0] pat;
        logic [3:0] len;
        logic       ovl;
        logic       same;
        logic [7:0] word;
        logic [7:0] exp_pulses;
        int         exp_cnt;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [7:0]  pulses;
        logic [15:0] pm16;
        n_vec = 0;
        n_err = 0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        s_data      = '0;

        // pulse bit k = cycle N+1+k after acceptance at edge N
        tbl[0] = '{8'h05, 4'd3,  1'b1, 1'b0, 8'hA8, 8'h14, 2};
        tbl[1] = '{8'h05, 4'd3,  1'b0, 1'b0, 8'hA8, 8'h04, 1};
        tbl[2] = '{8'hFF, 4'd8,  1'b1, 1'b0, 8'hFF, 8'h80, 1};
        tbl[3] = '{8'h06, 4'd3,  1'b1, 1'b0, 8'hDB, 8'h24, 2};
        tbl[4] = '{8'h05, 4'd0,  1'b1, 1'b0, 8'hA8, 8'h00, 0};
        tbl[5] = '{8'hAA, 4'd12, 1'b1, 1'b0, 8'hAA, 8'h80, 1};
        tbl[6] = '{8'h01, 4'd1,  1'b0, 1'b0, 8'hA8, 8'h15, 3};
        tbl[7] = '{8'h03, 4'd2,  1'b1, 1'b1, 8'hC0, 8'h02, 1};

        do_reset();

        // Defaults straight out of reset: 101 with overlap.
        send_word(8'hA8, pulses);
        chk("default_pulses", 32'(pulses), 32'h14);
        tick();
        chk("default_cnt", 32'(obs_cnt), 32'd2);

        for (int t = 0; t < 8; t++) begin
            do_reset();
            cfg_we      = 1'b1;
            cfg_pattern = tbl[t].pat;
            cfg_len     = tbl[t].len;
            cfg_overlap = tbl[t].ovl;
            if (!tbl[t].same) begin
                tick();
                cfg_we = 1'b0;
            end
            send_word(tbl[t].word, pulses);
            chk($sformatf("tbl%0d_pulses", t), 32'(pulses), 32'(tbl[t].exp_pulses));
            tick();
            chk($sformatf("tbl%0d_cnt", t), 32'(obs_cnt), 32'(tbl[t].exp_cnt));
        end

        // Back-to-back words 0x01, 0x40 with valid held; match spans the boundary.
        do_reset();
        s_valid = 1'b1;
        s_data  = 8'h01;
        tick();
        s_data = 8'h40;
        pm16   = '0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            pm16[k-1] = obs_out;
            if (k == 7) chk("b2b_ready_k7", 32'(obs_ready), 32'd0);
            if (k == 8) begin
                chk("b2b_ready_last", 32'(obs_ready), 32'd1);
                s_valid = 1'b0;
            end
            if (k == 9) chk("b2b_no_bubble", 32'(obs_busy), 32'd1);
        end
        chk("b2b_pulses", 32'(pm16), 32'h0200);

        // Config write while busy is dropped and flagged.
        do_reset();
        cfg_we = 1'b1; cfg_pattern = 8'hFF; cfg_len = 4'd8; cfg_overlap = 1'b1;
        tick();
        cfg_we  = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'hFF;
        tick();
        s_valid = 1'b0;
        pulses  = '0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 2) begin
                cfg_we = 1'b1; cfg_pattern = 8'h0F; cfg_len = 4'd4;
            end
            tick();
            cfg_we = 1'b0;
            pulses[k-1] = obs_out;
            if (k == 3) chk("busy_cfg_err", 32'(obs_err), 32'd1);
        end
        chk("busy_cfg_unchanged", 32'(pulses), 32'h80);

        // Narrow counter saturates on a stream of 0xAA.
        do_reset();
        s_valid = 1'b1;
        s_data  = 8'hAA;
        for (int k = 0; k < 32; k++) tick();
        s_valid = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk("cnt2_saturate", 32'(obs_cnt2), 32'd3);

        // cnt_clr coincident with a match leaves the count at 1.
        do_reset();
        s_valid = 1'b1;
        s_data  = 8'hAA;
        tick();
        s_valid = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        cnt_clr = 1'b1;
        tick();
        chk("clr_with_out_pulse", 32'(obs_out), 32'd1);
        cnt_clr = 1'b0;
        tick();
        chk("clr_with_out_cnt", 32'(obs_cnt), 32'd1);
        chk("clr_with_out_cnt2", 32'(obs_cnt2), 32'd1);

        // Reset during the 4th bit, then a clean word.
        do_reset();
        s_valid = 1'b1;
        s_data  = 8'hAD;
        tick();
        s_valid = 1'b0;
        for (int k = 1; k <= 3; k++) tick();
        do_reset();
        send_word(8'hA0, pulses);
        chk("post_reset_pulses", 32'(pulses), 32'h04);

        // Randomised traffic checked cycle by cycle against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            s_valid     = ($urandom_range(0, 3) != 0);
            s_data      = 8'($urandom);
            cfg_we      = ($urandom_range(0, 40) == 0);
            cfg_pattern = 8'($urandom);
            cfg_len     = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                      : 4'($urandom_range(1, 4));
            cfg_overlap = 1'($urandom_range(0, 1));
            cnt_clr     = ($urandom_range(0, 150) == 0);
            if (c == 2000) begin
                reset = 1'b1;
                #1;
                model_reset();
                @(posedge clk);
                #1;
                reset = 1'b0;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
